// File: rtl/rfile_scbd_if.sv
// Register-file / scoreboard port bundle: read ports, write-back, issue and status.
interface rfile_scbd_if #(
   parameter int BW = 16,
   parameter int AW = 4
);
   logic [AW-1:0] ra_a;
   logic [AW-1:0] ra_b;
   logic [BW-1:0] rd_a;
   logic [BW-1:0] rd_b;
   logic          we;
   logic [AW-1:0] wa;
   logic [BW-1:0] wd;
   logic          iss;
   logic [AW-1:0] iss_a;
   logic          busy_a;
   logic          busy_b;
   logic          stall;
   logic          err;

   modport master (
      output ra_a, ra_b, we, wa, wd, iss, iss_a,
      input  rd_a, rd_b, busy_a, busy_b, stall, err
   );

   modport slave (
      input  ra_a, ra_b, we, wa, wd, iss, iss_a,
      output rd_a, rd_b, busy_a, busy_b, stall, err
   );
endinterface

// File: rtl/rfile_scbd.sv
// Two-read/one-write register file with per-register pending (scoreboard) bits.
// Define RFILE_SCBD_BYPASS_EN to forward write-back data to same-cycle reads.
module rfile_scbd #(
   parameter int BW      = 16,
   parameter int NREG    = 16,
   parameter int AW      = 4,
   parameter int ZERO_R0 = 0
) (
   input  logic         clk,
   input  logic         rstn,
   rfile_scbd_if.slave  bus
);

   localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < NREG_W;
   endfunction

   function automatic logic is_r0(input logic [AW-1:0] a);
      return (ZERO_R0 != 0) && (a == '0);
   endfunction

   logic [BW-1:0] reg_q [NREG];
   logic [BW-1:0] reg_d [NREG];
   logic [NREG-1:0] pend_q, pend_d;
   logic          err_q, err_d;

   logic          wr_en, iss_en;
   logic [BW-1:0] rd_a, rd_b;
   logic          busy_a, busy_b, pend_iss;

   // R0 with ZERO_R0 is never written or issued, so it stays 0 and never pending.
   assign wr_en  = bus.we  && in_range(bus.wa)    && !is_r0(bus.wa);
   assign iss_en = bus.iss && in_range(bus.iss_a) && !is_r0(bus.iss_a);

   always_comb begin
      reg_d  = reg_q;
      pend_d = pend_q;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (wr_en && bus.wa == AW'(i)) begin
            reg_d[i]  = bus.wd;
            pend_d[i] = 1'b0;
         end
         // Issue evaluated last so it wins over a same-cycle write-back.
         if (iss_en && bus.iss_a == AW'(i)) begin
            pend_d[i] = 1'b1;
         end
      end
      err_d = err_q | (bus.we && !in_range(bus.wa)) | (bus.iss && !in_range(bus.iss_a));
   end

   always_comb begin
      rd_a     = '0;
      rd_b     = '0;
      busy_a   = 1'b0;
      busy_b   = 1'b0;
      pend_iss = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (bus.ra_a == AW'(i)) begin
            rd_a   = reg_q[i];
            busy_a = pend_q[i];
         end
         if (bus.ra_b == AW'(i)) begin
            rd_b   = reg_q[i];
            busy_b = pend_q[i];
         end
         if (bus.iss_a == AW'(i)) begin
            pend_iss = pend_q[i];
         end
      end
`ifdef RFILE_SCBD_BYPASS_EN
      if (wr_en && bus.ra_a == bus.wa) begin
         rd_a   = bus.wd;
         busy_a = iss_en && (bus.iss_a == bus.wa);
      end
      if (wr_en && bus.ra_b == bus.wa) begin
         rd_b   = bus.wd;
         busy_b = iss_en && (bus.iss_a == bus.wa);
      end
`endif
   end

   assign bus.rd_a   = rd_a;
   assign bus.rd_b   = rd_b;
   assign bus.busy_a = busy_a;
   assign bus.busy_b = busy_b;
   assign bus.err    = err_q;
   assign bus.stall  = busy_a | busy_b |
                       (iss_en && pend_iss && !(wr_en && bus.wa == bus.iss_a));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            reg_q[i] <= '0;
         end
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         reg_q  <= reg_d;
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: tb/tb_rfile_scbd.sv
// Directed self-checking bench for rfile_scbd: default instance plus NREG=12/ZERO_R0=1 instance.
module tb_rfile_scbd;

`ifdef RFILE_SCBD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rfile_scbd_if #(.BW(16), .AW(4)) m1 ();
   rfile_scbd_if #(.BW(16), .AW(4)) m2 ();

   rfile_scbd #(.BW(16), .NREG(16), .AW(4), .ZERO_R0(0)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (m1)
   );

   rfile_scbd #(.BW(16), .NREG(12), .AW(4), .ZERO_R0(1)) u_dut2 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (m2)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      m1.ra_a = '0; m1.ra_b = '0; m1.we = 1'b0; m1.wa = '0; m1.wd = '0; m1.iss = 1'b0; m1.iss_a = '0;
      m2.ra_a = '0; m2.ra_b = '0; m2.we = 1'b0; m2.wa = '0; m2.wd = '0; m2.iss = 1'b0; m2.iss_a = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_rd_a",  m1.rd_a,  16'h0);
      check_eq("rst_busy",  {m1.busy_a, m1.busy_b, m1.stall}, 3'b000);
      check_eq("rst_err",   m1.err,   1'b0);
      rstn = 1'b1;

      // Write 0x1234 to r5, read back next cycle
      m1.ra_a = 4'd5; m1.we = 1'b1; m1.wa = 4'd5; m1.wd = 16'h1234;
      #1;
      check_eq("wr_cycle_rd_a", m1.rd_a, BYP ? 16'h1234 : 16'h0000);
      tick();
      m1.we = 1'b0;
      #1;
      check_eq("r5_rd_a",   m1.rd_a,   16'h1234);
      check_eq("r5_busy_a", m1.busy_a, 1'b0);

      // Issue r3, then write-back clears pending
      m1.iss = 1'b1; m1.iss_a = 4'd3;
      tick();
      m1.iss = 1'b0; m1.ra_b = 4'd3;
      #1;
      check_eq("r3_busy_b", m1.busy_b, 1'b1);
      check_eq("r3_stall",  m1.stall,  1'b1);
      m1.we = 1'b1; m1.wa = 4'd3; m1.wd = 16'h00AA;
      #1;
      check_eq("r3_wb_busy_b", m1.busy_b, BYP ? 1'b0 : 1'b1);
      check_eq("r3_wb_rd_b",   m1.rd_b,   BYP ? 16'h00AA : 16'h0000);
      tick();
      m1.we = 1'b0;
      #1;
      check_eq("r3_clr_busy_b", m1.busy_b, 1'b0);
      check_eq("r3_rd_b",       m1.rd_b,   16'h00AA);
      check_eq("r3_clr_stall",  m1.stall,  1'b0);

      // Same-cycle issue and write to r7: data lands, pending stays
      m1.iss = 1'b1; m1.iss_a = 4'd7; m1.we = 1'b1; m1.wa = 4'd7; m1.wd = 16'h0F0F;
      tick();
      m1.iss = 1'b0; m1.we = 1'b0; m1.ra_a = 4'd7;
      #1;
      check_eq("r7_rd_a",   m1.rd_a,   16'h0F0F);
      check_eq("r7_busy_a", m1.busy_a, 1'b1);
      check_eq("r7_stall",  m1.stall,  1'b1);

      // Issue to a pending register stalls unless that register is cleared this cycle
      m1.ra_a = 4'd5; m1.iss = 1'b1; m1.iss_a = 4'd7;
      #1;
      check_eq("iss_pend_stall", m1.stall, 1'b1);
      m1.we = 1'b1; m1.wa = 4'd7; m1.wd = 16'h7777;
      #1;
      check_eq("iss_clr_stall", m1.stall, 1'b0);
      m1.iss = 1'b0; m1.we = 1'b0;

      // Both ports on the same address
      m1.ra_a = 4'd5; m1.ra_b = 4'd5;
      #1;
      check_eq("dual_rd_a", m1.rd_a, 16'h1234);
      check_eq("dual_rd_b", m1.rd_b, 16'h1234);

      // Read-during-write of r2
      m1.we = 1'b1; m1.wa = 4'd2; m1.wd = 16'hBEEF; m1.ra_a = 4'd2;
      #1;
      check_eq("r2_rdw_rd_a", m1.rd_a, BYP ? 16'hBEEF : 16'h0000);
      tick();
      m1.we = 1'b0;
      #1;
      check_eq("r2_rd_a", m1.rd_a, 16'hBEEF);

      // Second instance: R0 hard-wired zero, no err
      m2.we = 1'b1; m2.wa = 4'd0; m2.wd = 16'hFFFF; m2.iss = 1'b1; m2.iss_a = 4'd0; m2.ra_a = 4'd0;
      tick();
      m2.we = 1'b0; m2.iss = 1'b0;
      #1;
      check_eq("z0_rd_a",   m2.rd_a,   16'h0);
      check_eq("z0_busy_a", m2.busy_a, 1'b0);
      check_eq("z0_err",    m2.err,    1'b0);

      // Highest legal register
      m2.we = 1'b1; m2.wa = 4'd11; m2.wd = 16'h1111; m2.ra_b = 4'd11;
      tick();
      m2.we = 1'b0;
      #1;
      check_eq("r11_rd_b", m2.rd_b, 16'h1111);

      // Out-of-range write: ignored, err sticky
      m2.we = 1'b1; m2.wa = 4'd14; m2.wd = 16'h5A5A; m2.ra_a = 4'd14;
      #1;
      check_eq("oor_rdw_rd_a", m2.rd_a, 16'h0);
      tick();
      m2.we = 1'b0;
      #1;
      check_eq("oor_err",    m2.err,    1'b1);
      check_eq("oor_rd_a",   m2.rd_a,   16'h0);
      check_eq("oor_busy_a", m2.busy_a, 1'b0);
      check_eq("oor_r11",    m2.rd_b,   16'h1111);
      repeat (3) tick();
      check_eq("oor_err_sticky", m2.err, 1'b1);

      // Reset asserted mid-cycle with concurrent write and issue
      m1.we = 1'b1; m1.wa = 4'd9; m1.wd = 16'h5555; m1.iss = 1'b1; m1.iss_a = 4'd9;
      m1.ra_a = 4'd2; m1.ra_b = 4'd7;
      #2;
      rstn = 1'b0;
      #1;
      check_eq("async_rd_a",   m1.rd_a,   16'h0);
      check_eq("async_busy_b", m1.busy_b, 1'b0);
      check_eq("async_err2",   m2.err,    1'b0);
      tick();
      rstn = 1'b1; m1.we = 1'b0; m1.iss = 1'b0; m1.ra_a = 4'd9; m1.ra_b = 4'd2;
      #1;
      check_eq("post_rst_rd",   {m1.rd_a, m1.rd_b}, 32'h0);
      check_eq("post_rst_busy", {m1.busy_a, m1.busy_b, m1.stall, m1.err}, 4'b0000);

      // First write after release takes effect on the first edge
      m1.we = 1'b1; m1.wa = 4'd4; m1.wd = 16'h4444; m1.ra_a = 4'd4;
      tick();
      m1.we = 1'b0;
      #1;
      check_eq("first_wr_rd_a", m1.rd_a, 16'h4444);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
